// File: rtl/i2c_pkg.sv
// Shared constants for the I2C block: TX FIFO geometry and status-register layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   TX_FIFO_DEPTH / TX_FIFO_DATA_W  default TX FIFO geometry
//   TX_FIFO_PTR_W / TX_FIFO_CNT_W   pointer and occupancy widths for that geometry
//   STAT_*_BIT                      bit positions of FIFO flags in the status register
//   tx_fifo_status()                packs the four flags into status-register order
package i2c_pkg;

    localparam int TX_FIFO_DEPTH  = 16;
    localparam int TX_FIFO_DATA_W = 8;
    localparam int TX_FIFO_PTR_W  = $clog2(TX_FIFO_DEPTH);
    // One extra bit so that "completely full" (== DEPTH) is representable.
    localparam int TX_FIFO_CNT_W  = TX_FIFO_PTR_W + 1;

    localparam int STAT_FULL_BIT      = 0;
    localparam int STAT_EMPTY_BIT     = 1;
    localparam int STAT_OVERFLOW_BIT  = 2;
    localparam int STAT_UNDERFLOW_BIT = 3;
    localparam int STAT_W             = 4;

    function automatic logic [STAT_W-1:0] tx_fifo_status(
        input logic full,
        input logic empty,
        input logic overflow,
        input logic underflow
    );
        logic [STAT_W-1:0] s;
        s                     = '0;
        s[STAT_FULL_BIT]      = full;
        s[STAT_EMPTY_BIT]     = empty;
        s[STAT_OVERFLOW_BIT]  = overflow;
        s[STAT_UNDERFLOW_BIT] = underflow;
        return s;
    endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// Storage array for the I2C TX FIFO: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge; read data follows rd_addr combinationally.
// Backpressure: none; the owner decides when a write is legal.
//
// Ports:
//   clk      rising-edge clock
//   wr_en    write strobe (already qualified by the owner)
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  contents of mem[rd_addr]
module i2c_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    // No reset: contents are only ever observed through pointers that are reset.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2c_tx_fifo.sv
// I2C transmit byte FIFO between the AXI register write path and the I2C controller FSM.
// Latency: push visible in count/empty/full after one edge; popped data valid the cycle after read_request.
// Backpressure: pushes while full are dropped, pops while empty are ignored; no stall signalling.
//
// Ports:
//   axi_clk, axi_reset     clock and synchronous active-high reset
//   wr_en, wr_data         push request; only wr_data[DATA_W-1:0] is stored
//   flush                  single-cycle clear of pointers, count, output data and error flags
//   read_request           pop pulse from the controller
//   data_from_fifo         last popped entry, zero-extended to 32 bits
//   full, empty, count     registered occupancy status
//   overflow, underflow    sticky error flags
//
// Build option: define I2C_TX_FIFO_ERR_FLAGS_EN to implement the overflow/underflow
// flags; otherwise both outputs are constant 0.
module i2c_tx_fifo
    import i2c_pkg::*;
#(
    parameter int DEPTH  = TX_FIFO_DEPTH,
    parameter int DATA_W = TX_FIFO_DATA_W
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    input  logic                     flush,
    input  logic                     read_request,
    output logic [31:0]              data_from_fifo,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] rd_dat;
    logic [CNT_W-1:0]  count_nxt;
    logic              push_ok;
    logic              pop_ok;
    logic              mem_wr;

    // Qualification uses the registered flags, so a push/pop pair while full
    // resolves to pop-only and while empty to push-only.
    assign push_ok = wr_en && !full;
    assign pop_ok  = read_request && !empty;

    // Flush and reset cancel the push; gating keeps the array quiet on those cycles.
    assign mem_wr  = push_ok && !flush && !axi_reset;

    i2c_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (axi_clk),
        .wr_en   (mem_wr),
        .wr_addr (wr_ptr),
        .wr_data (wr_data[DATA_W-1:0]),
        .rd_addr (rd_ptr),
        .rd_data (rd_dat)
    );

    // Upper write-data bits are architecturally ignored.
    generate
        if (DATA_W < 32) begin : g_unused_wdata
            logic unused_wr_data_hi;
            assign unused_wr_data_hi = ^wr_data[31:DATA_W];
        end
    endgenerate

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers are PTR_W bits and DEPTH is a power of two, so the natural
    // binary roll-over is the DEPTH-1 -> 0 wrap.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_from_fifo <= '0;
            empty          <= 1'b1;
            full           <= 1'b0;
        end else if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_from_fifo <= '0;
            empty          <= 1'b1;
            full           <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                data_from_fifo <= 32'(rd_dat);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == DEPTH_CNT);
        end
    end

`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    // Sticky: once set, only flush or reset clears them.
    always_ff @(posedge axi_clk) begin
        if (axi_reset || flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (read_request && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/i2c_tx_fifo.md
I2C_TX_FIFO -- requirements
Module: i2c_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; the value SHALL be a power of two and at least 2.
REQ-002 Parameter DATA_W, default 8, width of one stored entry.
REQ-003 Port axi_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port axi_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port wr_en, input, 1 bit: push request from the AXI register write to the TX data address.
REQ-006 Port wr_data, input, 32 bits: AXI write data; only bits [DATA_W-1:0] SHALL be stored.
REQ-007 Port flush, input, 1 bit: single-cycle clear request from the control register.
REQ-008 Port read_request, input, 1 bit: pop pulse from the I2C controller FSM.
REQ-009 Port data_from_fifo, output, 32 bits: the last popped entry, zero-extended to 32 bits.
REQ-010 Port full, output, 1 bit: high when count equals DEPTH.
REQ-011 Port empty, output, 1 bit: high when count equals 0.
REQ-012 Port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 Port overflow, output, 1 bit: sticky error flag (see REQ-025).
REQ-014 Port underflow, output, 1 bit: sticky error flag (see REQ-025).

Function
REQ-015 Storage SHALL be a circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits each; both pointers SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-016 A push SHALL occur when wr_en=1 and full=0; the entry is written at wr_ptr and wr_ptr increments on the same edge.
REQ-017 A pop SHALL occur when read_request=1 and empty=0; mem[rd_ptr] is registered into data_from_fifo and rd_ptr increments.
REQ-018 Pop latency SHALL be one cycle: data_from_fifo is valid on the cycle after read_request and holds until the next successful pop, flush, or reset.
REQ-019 When a push and a pop occur on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 A simultaneous push and pop while empty=1 SHALL perform only the push; this is counted as an underflow, and data_from_fifo is unchanged.
REQ-021 A simultaneous push and pop while full=1 SHALL perform only the pop; this is counted as an overflow.
REQ-022 A push while full SHALL be dropped, with no change to pointers or memory.
REQ-023 A pop while empty SHALL leave data_from_fifo and the pointers unchanged.
REQ-024 flush=1 SHALL zero wr_ptr, rd_ptr, count, and data_from_fifo, and SHALL take priority over any push or pop on the same cycle. Memory contents need not be cleared.
REQ-025 overflow SHALL set on a dropped push and underflow SHALL set on an empty pop; both SHALL clear only on flush or reset.
REQ-026 full, empty, and count SHALL be registered, reflecting state after the most recent edge, with no combinational path from inputs.

Reset
REQ-027 While axi_reset=1 at an edge, the following SHALL be forced: pointers=0, count=0, data_from_fifo=0, overflow=0, underflow=0, empty=1, full=0.
REQ-028 Reset SHALL take priority over flush, push, and pop; a reset mid-transfer discards all entries.

Configuration
REQ-029 With macro I2C_TX_FIFO_ERR_FLAGS_EN defined, the overflow and underflow logic SHALL be present as specified in REQ-025.
REQ-030 Without I2C_TX_FIFO_ERR_FLAGS_EN, overflow and underflow SHALL be tied to 0; all other behaviour is identical.

Structure
REQ-031 Package i2c_pkg SHALL hold: TX_FIFO_DEPTH (16), TX_FIFO_DATA_W (8), status-register bit positions for full/empty/overflow/underflow, and the count width localparam.
REQ-032 Storage SHALL be a sub-module, i2c_fifo_mem: a simple dual-port array with one synchronous write port and one combinational read port; pointer and flag logic remain in i2c_tx_fifo.

Verification
REQ-033 Scenario: reset, then push 0xA5, 0x3C. Required: count=2 and empty=0; read_request -> data_from_fifo=0x000000A5 next cycle; second pop -> 0x0000003C; empty=1.
REQ-034 Scenario: push 17 bytes (0x00..0x10) with DEPTH=16. Required: full=1 after the 16th push; the 17th push is dropped; overflow=1; popping 16 times yields 0x00..0x0F in order.
REQ-035 Scenario: fill to 16, then assert wr_en and read_request together. Required: pop only, count=15, overflow=1; a later push/pop pair at count=5 leaves count=5.
REQ-036 Scenario: read_request while empty. Required: underflow=1; data_from_fifo keeps its prior value; count=0.
REQ-037 Scenario: push 20 bytes with interleaved pops across pointer wrap. Required: output order matches input order exactly.
REQ-038 Scenario: flush with count=7 on the same cycle as a push. Required: count=0, empty=1, data_from_fifo=0, flags cleared, push discarded; then assert axi_reset mid-fill and check the REQ-027 values.
